// File: rtl/axis_i2c_cmd_packer_if.sv
// Byte stream into the I2C command packer: AXI4-Stream style valid/ready
// handshake with a last-beat marker.
interface axis_i2c_cmd_packer_if;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic       s_axis_tlast;

  modport master (
    output s_axis_tdata,
    output s_axis_tvalid,
    output s_axis_tlast,
    input  s_axis_tready
  );

  modport slave (
    input  s_axis_tdata,
    input  s_axis_tvalid,
    input  s_axis_tlast,
    output s_axis_tready
  );
endinterface

// File: rtl/axis_i2c_cmd_packer.sv
// Packs a byte stream (address beat followed by data beats) into {addr,data}
// write strobes for an i2c_master command FIFO, with short/read error pulses.
module axis_i2c_cmd_packer #(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 arst,
  axis_i2c_cmd_packer_if.slave s_axis,
  output logic [6:0]           addr,
  output logic [7:0]           data,
  output logic                 fifo_wr_en,
  input  logic                 fifo_full,
  output logic                 err_short,
  output logic                 err_rd,
  output logic [CNT_W-1:0]     pkt_cnt
);

  typedef enum logic [1:0] {
    ST_ADDR,
    ST_DATA,
    ST_DROP
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [6:0]       r_addr_lat;
  logic [6:0]       r_addr;
  logic [7:0]       r_data;
  logic             r_wr_en;
  logic             r_err_short;
  logic             r_err_rd;
  logic [CNT_W-1:0] r_pkt_cnt;

  logic w_tready;
  logic w_accept;
  logic w_wr;
  logic w_err_short;
  logic w_err_rd;
  logic w_lat_load;
  logic w_pkt_inc;

  // DATA stalls during its own strobe cycle so a FIFO-full raised in reply
  // to that write is seen before the next byte is taken.
  assign w_tready = arst ? 1'b0 :
                    (r_state == ST_DATA) ? (!fifo_full && !r_wr_en) : 1'b1;
  assign w_accept = s_axis.s_axis_tvalid && w_tready;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state <= ST_ADDR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wr        = 1'b0;
    w_err_short = 1'b0;
    w_err_rd    = 1'b0;
    w_lat_load  = 1'b0;
    w_pkt_inc   = 1'b0;
    case (r_state)
      ST_ADDR: begin
        if (w_accept) begin
          if (s_axis.s_axis_tdata[7]) begin
            w_err_rd = 1'b1;
            if (!s_axis.s_axis_tlast) begin
              w_state_nxt = ST_DROP;
            end
          end else if (s_axis.s_axis_tlast) begin
            w_err_short = 1'b1;
          end else begin
            w_lat_load  = 1'b1;
            w_state_nxt = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (w_accept) begin
          w_wr = 1'b1;
          if (s_axis.s_axis_tlast) begin
            w_pkt_inc   = 1'b1;
            w_state_nxt = ST_ADDR;
          end
        end
      end
      ST_DROP: begin
        if (w_accept && s_axis.s_axis_tlast) begin
          w_state_nxt = ST_ADDR;
        end
      end
      default: begin
        w_state_nxt = ST_ADDR;
      end
    endcase
  end

  // Output stage: strobes and payload register one cycle after acceptance.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_addr_lat  <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_wr_en     <= 1'b0;
      r_err_short <= 1'b0;
      r_err_rd    <= 1'b0;
      r_pkt_cnt   <= '0;
    end else begin
      r_wr_en     <= w_wr;
      r_err_short <= w_err_short;
      r_err_rd    <= w_err_rd;
      if (w_lat_load) begin
        r_addr_lat <= s_axis.s_axis_tdata[6:0];
      end
      if (w_wr) begin
        r_addr <= r_addr_lat;
        r_data <= s_axis.s_axis_tdata;
      end
      if (w_pkt_inc) begin
        r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
      end
    end
  end

  assign s_axis.s_axis_tready = w_tready;
  assign addr                 = r_addr;
  assign data                 = r_data;
  assign fifo_wr_en           = r_wr_en;
  assign err_short            = r_err_short;
  assign err_rd               = r_err_rd;
  assign pkt_cnt              = r_pkt_cnt;

endmodule

// File: tb/tb_axis_i2c_cmd_packer.sv
// Directed bench for axis_i2c_cmd_packer: expected {addr,data} strobes are
// queued as packets are driven and popped as the DUT writes its FIFO port.
module tb_axis_i2c_cmd_packer;

  localparam int CNT_W = 2;

  logic             clk;
  logic             arst;
  logic [6:0]       addr;
  logic [7:0]       data;
  logic             fifo_wr_en;
  logic             fifo_full;
  logic             err_short;
  logic             err_rd;
  logic [CNT_W-1:0] pkt_cnt;

  axis_i2c_cmd_packer_if u_if ();

  axis_i2c_cmd_packer #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .arst       (arst),
    .s_axis     (u_if),
    .addr       (addr),
    .data       (data),
    .fifo_wr_en (fifo_wr_en),
    .fifo_full  (fifo_full),
    .err_short  (err_short),
    .err_rd     (err_rd),
    .pkt_cnt    (pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          n_wr  = 0;
  int          n_es  = 0;
  int          n_er  = 0;
  int          last_strobe = 0;
  int          prev_strobe = 0;
  logic [14:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock; the write port and error pulses are checked after every edge.
  task automatic tick();
    logic        full_before;
    logic [14:0] e;
    full_before = fifo_full;
    @(posedge clk);
    #1;
    cyc++;
    chk("err_exclusive", 32'(err_short & err_rd), 32'h0);
    if (fifo_wr_en) begin
      n_wr++;
      chk("wr_after_full", 32'(full_before), 32'h0);
      chk("sb_nonempty", 32'(exp_q.size() > 0), 32'h1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("strobe_addr_data", 32'({addr, data}), 32'(e));
      end
      prev_strobe = last_strobe;
      last_strobe = cyc;
    end
    if (err_short) n_es++;
    if (err_rd)    n_er++;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic l);
    logic ok;
    ok = 1'b0;
    u_if.s_axis_tdata  = d;
    u_if.s_axis_tlast  = l;
    u_if.s_axis_tvalid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      #1;
      ok = u_if.s_axis_tready;
      tick();
    end
    chk("beat_accepted", 32'(ok), 32'h1);
  endtask

  task automatic idle(input int n);
    u_if.s_axis_tvalid = 1'b0;
    u_if.s_axis_tdata  = 8'hxx;
    u_if.s_axis_tlast  = 1'bx;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    #2;
    arst = 1'b1;
    #1;
    chk("rst_tready", 32'(u_if.s_axis_tready), 32'h0);
    chk("rst_outputs", 32'({addr, data, fifo_wr_en, err_short, err_rd, pkt_cnt}), 32'h0);
    tick();
    arst = 1'b0;
    #1;
    chk("post_rst_tready", 32'(u_if.s_axis_tready), 32'h1);
  endtask

  int n0;
  int exp_cnt[5];

  initial begin
    exp_cnt = '{1, 2, 3, 0, 1};
    arst = 1'b0;
    fifo_full = 1'b0;
    u_if.s_axis_tvalid = 1'b0;
    u_if.s_axis_tdata  = 8'h00;
    u_if.s_axis_tlast  = 1'b0;
    #1;
    arst = 1'b1;
    #1;
    chk("reset_tready", 32'(u_if.s_axis_tready), 32'h0);
    chk("reset_outputs", 32'({addr, data, fifo_wr_en, err_short, err_rd, pkt_cnt}), 32'h0);
    tick();
    tick();
    arst = 1'b0;
    #1;
    chk("release_tready", 32'(u_if.s_axis_tready), 32'h1);
    tick();
    chk("first_edge_tready", 32'(u_if.s_axis_tready), 32'h1);

    // Basic packet
    exp_q.push_back({7'h50, 8'hA5});
    exp_q.push_back({7'h50, 8'h3C});
    send_beat(8'h50, 1'b0);
    send_beat(8'hA5, 1'b0);
    send_beat(8'h3C, 1'b1);
    chk("basic_last_wr", 32'(fifo_wr_en), 32'h1);
    chk("basic_cnt_same_cycle", 32'(pkt_cnt), 32'h1);
    chk("basic_gap", 32'(last_strobe - prev_strobe), 32'h2);
    idle(3);
    chk("basic_hold", 32'({addr, data}), 32'({7'h50, 8'h3C}));
    chk("basic_sb_empty", 32'(exp_q.size()), 32'h0);
    chk("basic_strobes", 32'(n_wr), 32'h2);
    chk("basic_no_err", 32'(n_es + n_er), 32'h0);

    // Short packet
    n0 = n_wr;
    send_beat(8'h21, 1'b1);
    chk("short_pulse", 32'({err_short, err_rd, fifo_wr_en}), 32'h4);
    idle(3);
    chk("short_count", 32'(n_es), 32'h1);
    chk("short_no_wr", 32'(n_wr - n0), 32'h0);
    chk("short_cnt", 32'(pkt_cnt), 32'h1);

    // Read request dropped, then a normal packet
    n0 = n_wr;
    send_beat(8'hC8, 1'b0);
    chk("rd_pulse", 32'({err_short, err_rd}), 32'h1);
    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b1);
    idle(2);
    chk("rd_count", 32'(n_er), 32'h1);
    chk("rd_no_wr", 32'(n_wr - n0), 32'h0);
    exp_q.push_back({7'h10, 8'h77});
    send_beat(8'h10, 1'b0);
    send_beat(8'h77, 1'b1);
    idle(2);
    chk("rd_next_wr", 32'(n_wr - n0), 32'h1);
    chk("rd_next_cnt", 32'(pkt_cnt), 32'h2);
    chk("rd_short_untouched", 32'(n_es), 32'h1);

    // Backpressure: FIFO goes full right after the first data write
    n0 = n_wr;
    for (int b = 1; b <= 4; b++) exp_q.push_back({7'h33, 8'(8'hB0 + b)});
    send_beat(8'h33, 1'b0);
    send_beat(8'hB1, 1'b0);
    fifo_full = 1'b1;
    u_if.s_axis_tdata = 8'hB2;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("bp_tready", 32'(u_if.s_axis_tready), 32'h0);
      tick();
    end
    chk("bp_no_wr_while_full", 32'(n_wr - n0), 32'h1);
    fifo_full = 1'b0;
    send_beat(8'hB2, 1'b0);
    send_beat(8'hB3, 1'b0);
    send_beat(8'hB4, 1'b1);
    idle(3);
    chk("bp_writes", 32'(n_wr - n0), 32'h4);
    chk("bp_sb_empty", 32'(exp_q.size()), 32'h0);
    chk("bp_cnt", 32'(pkt_cnt), 32'h3);

    // Reset mid-packet, with a beat offered as reset rises
    exp_q.push_back({7'h44, 8'hE1});
    send_beat(8'h44, 1'b0);
    send_beat(8'hE1, 1'b0);
    u_if.s_axis_tdata = 8'hE2;
    u_if.s_axis_tlast = 1'b0;
    tick();
    n0 = n_wr;
    do_reset();
    exp_q.push_back({7'h05, 8'h99});
    send_beat(8'h05, 1'b0);
    send_beat(8'h99, 1'b1);
    idle(3);
    chk("mid_rst_wr", 32'(n_wr - n0), 32'h1);
    chk("mid_rst_sb_empty", 32'(exp_q.size()), 32'h0);
    chk("mid_rst_cnt", 32'(pkt_cnt), 32'h1);

    // Counter wrap with a 2-bit counter
    do_reset();
    for (int p = 0; p < 5; p++) begin
      exp_q.push_back({7'h12, 8'(p)});
      send_beat(8'h12, 1'b0);
      send_beat(8'(p), 1'b1);
      idle(1);
      chk("wrap_cnt", 32'(pkt_cnt), 32'(exp_cnt[p]));
    end
    chk("wrap_sb_empty", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
